// File: rtl/multicycle_ctrl.sv
`timescale 1ns/1ps
// multicycle_ctrl -- main control FSM of a multicycle RV32I-subset datapath.
// Moore-style sequencing over a unified memory: every state lasts one cycle
// except FETCH/MEMRD/MEMWR, which hold until mem_ready. All outputs are held
// at 0 while reset is asserted and until the first clock edge after release.
module multicycle_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        addr_src,
   output logic        ir_write,
   output logic        pc_write,
   output logic        reg_write,
   output logic [1:0]  alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [2:0]  alu_ctrl,
   output logic [2:0]  imm_src,
   output logic [1:0]  result_src,
   output logic        illegal,
   output logic [3:0]  state
);

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_MEMADR = 4'd2;
   localparam logic [3:0] S_MEMRD  = 4'd3;
   localparam logic [3:0] S_MEMWB  = 4'd4;
   localparam logic [3:0] S_MEMWR  = 4'd5;
   localparam logic [3:0] S_EXECR  = 4'd6;
   localparam logic [3:0] S_EXECI  = 4'd7;
   localparam logic [3:0] S_ALUWB  = 4'd8;
   localparam logic [3:0] S_BRANCH = 4'd9;
   localparam logic [3:0] S_JAL    = 4'd10;
   localparam logic [3:0] S_JALR   = 4'd11;
   localparam logic [3:0] S_JALR2  = 4'd12;
   localparam logic [3:0] S_LUI    = 4'd13;
   localparam logic [3:0] S_TRAP   = 4'd14;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;

   logic [3:0] state_q, state_d;
   // Goes high on the first edge after reset release; gates every output so
   // nothing is requested while rst_n is low or before that first edge.
   logic       run_q;

   logic [6:0] opcode;
   logic [2:0] funct3;

   logic       mem_req_c, mem_we_c, addr_src_c, ir_write_c, pc_write_c, reg_write_c;
   logic [1:0] alu_src_a_c, alu_src_b_c, result_src_c;
   logic [2:0] alu_ctrl_c, imm_src_c;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];

   // State register and run flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         run_q   <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         state_q <= state_d;
         run_q   <= 1'b1;
      end
   end

   // Next-state and per-state output decode.
   always_comb begin
      // NOTE: everything written here gets a default first, so no path can infer a latch.
      state_d      = state_q;
      mem_req_c    = 1'b0;
      mem_we_c     = 1'b0;
      addr_src_c   = 1'b0;
      ir_write_c   = 1'b0;
      pc_write_c   = 1'b0;
      reg_write_c  = 1'b0;
      alu_src_a_c  = 2'b00;
      alu_src_b_c  = 2'b00;
      alu_ctrl_c   = ALU_ADD;
      imm_src_c    = 3'b000;
      result_src_c = 2'b00;

      case (state_q)
         S_FETCH: begin
            mem_req_c    = 1'b1;
            alu_src_b_c  = 2'b10;
            result_src_c = 2'b10;
            if (mem_ready) begin
               ir_write_c = 1'b1;
               pc_write_c = 1'b1;
               state_d    = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_src_a_c = 2'b01;
            alu_src_b_c = 2'b01;
            imm_src_c   = (opcode == OP_JAL) ? 3'b011 : 3'b010;
            case (opcode)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECR;
               OP_ITYPE:          state_d = S_EXECI;
               OP_BRANCH:         state_d = S_BRANCH;
               OP_JAL:            state_d = S_JAL;
               OP_JALR:           state_d = S_JALR;
               OP_LUI:            state_d = S_LUI;
               default:           state_d = S_TRAP;
            endcase
         end
         S_MEMADR: begin
            alu_src_a_c = 2'b10;
            alu_src_b_c = 2'b01;
            // Only loads and stores reach this state.
            if (opcode == OP_STORE) begin
               imm_src_c = 3'b001;
               state_d   = S_MEMWR;
            end else begin
               state_d   = S_MEMRD;
            end
         end
         S_MEMRD: begin
            mem_req_c  = 1'b1;
            addr_src_c = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            reg_write_c  = 1'b1;
            result_src_c = 2'b01;
            state_d      = S_FETCH;
         end
         S_MEMWR: begin
            mem_req_c  = 1'b1;
            mem_we_c   = 1'b1;
            addr_src_c = 1'b1;
            if (mem_ready) state_d = S_FETCH;
         end
         S_EXECR, S_EXECI: begin
            alu_src_a_c = 2'b10;
            alu_src_b_c = (state_q == S_EXECI) ? 2'b01 : 2'b00;
            state_d     = S_ALUWB;
            case (funct3)
               3'b000:  alu_ctrl_c = (state_q == S_EXECR && instr[30]) ? ALU_SUB : ALU_ADD;
               3'b100:  alu_ctrl_c = ALU_XOR;
               3'b110:  alu_ctrl_c = ALU_OR;
               3'b111:  alu_ctrl_c = ALU_AND;
               default: state_d    = S_TRAP;
            endcase
         end
         S_ALUWB: begin
            reg_write_c = 1'b1;
            state_d     = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a_c = 2'b10;
            alu_ctrl_c  = ALU_SUB;
            state_d     = S_FETCH;
            case (funct3)
               3'b000:  pc_write_c = zero;
               3'b001:  pc_write_c = ~zero;
               default: state_d    = S_TRAP;
            endcase
         end
         S_JAL, S_JALR2: begin
            // Link value oldPC+4 is produced here and written back in ALUWB.
            alu_src_a_c = 2'b01;
            alu_src_b_c = 2'b10;
            pc_write_c  = 1'b1;
            state_d     = S_ALUWB;
         end
         S_JALR: begin
            alu_src_a_c = 2'b10;
            alu_src_b_c = 2'b01;
            state_d     = S_JALR2;
         end
         S_LUI: begin
            alu_src_a_c = 2'b11;
            alu_src_b_c = 2'b01;
            imm_src_c   = 3'b100;
            state_d     = S_ALUWB;
         end
         S_TRAP:  state_d = S_TRAP;
         default: state_d = S_TRAP;
      endcase

      // Hold in FETCH until the first post-reset edge has armed the outputs.
      if (!run_q) state_d = state_q;
   end

   assign mem_req    = run_q & mem_req_c;
   assign mem_we     = run_q & mem_we_c;
   assign addr_src   = run_q & addr_src_c;
   assign ir_write   = run_q & ir_write_c;
   assign pc_write   = run_q & pc_write_c;
   assign reg_write  = run_q & reg_write_c;
   assign alu_src_a  = run_q ? alu_src_a_c  : 2'b00;
   assign alu_src_b  = run_q ? alu_src_b_c  : 2'b00;
   assign alu_ctrl   = run_q ? alu_ctrl_c   : 3'b000;
   assign imm_src    = run_q ? imm_src_c    : 3'b000;
   assign result_src = run_q ? result_src_c : 2'b00;
   // TRAP is absorbing until reset, so the flag is sticky by construction.
   assign illegal    = run_q & (state_q == S_TRAP);
   assign state      = run_q ? state_q : 4'd0;

endmodule

// File: tb/tb_multicycle_ctrl.sv
`timescale 1ns/1ps
// Bench for multicycle_ctrl: a per-instruction reference model pushes the
// expected output bundle of every cycle into a scoreboard; a monitor on the
// falling edge pops and compares whatever the DUT presents.
module tb_multicycle_ctrl;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       addr_src;
      logic       ir_write;
      logic       pc_write;
      logic       reg_write;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_ctrl;
      logic [2:0] imm_src;
      logic [1:0] result_src;
      logic       illegal;
   } out_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [2:0] ADD = 3'b000;
   localparam logic [2:0] SUB = 3'b001;
   localparam logic [2:0] AND = 3'b010;
   localparam logic [2:0] OR  = 3'b011;
   localparam logic [2:0] XOR = 3'b100;

   logic        clk, rst_n;
   logic [31:0] instr;
   logic        zero, mem_ready;
   logic        mem_req, mem_we, addr_src, ir_write, pc_write, reg_write;
   logic [1:0]  alu_src_a, alu_src_b, result_src;
   logic [2:0]  alu_ctrl, imm_src;
   logic        illegal;
   logic [3:0]  state;

   int checks = 0;
   int errors = 0;

   out_t  exp_q[$];
   string name_q[$];

   multicycle_ctrl dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .addr_src(addr_src), .ir_write(ir_write),
      .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .imm_src(imm_src),
      .result_src(result_src), .illegal(illegal), .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic out_t act_out();
      out_t o;
      o.mem_req    = mem_req;
      o.mem_we     = mem_we;
      o.addr_src   = addr_src;
      o.ir_write   = ir_write;
      o.pc_write   = pc_write;
      o.reg_write  = reg_write;
      o.alu_src_a  = alu_src_a;
      o.alu_src_b  = alu_src_b;
      o.alu_ctrl   = alu_ctrl;
      o.imm_src    = imm_src;
      o.result_src = result_src;
      o.illegal    = illegal;
      return o;
   endfunction

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   // Output bundle of an ALU-only cycle (no strobes).
   function automatic out_t alu(logic [1:0] a, logic [1:0] b, logic [2:0] c,
                                logic [2:0] imm, logic [1:0] res);
      out_t o;
      o = '0;
      o.alu_src_a  = a;
      o.alu_src_b  = b;
      o.alu_ctrl   = c;
      o.imm_src    = imm;
      o.result_src = res;
      return o;
   endfunction

   // {valid, alu op} for an arithmetic funct3; sub only for register forms.
   function automatic logic [3:0] arith_op(logic [2:0] f3, logic sub_ok, logic b30);
      case (f3)
         3'b000:  return {1'b1, (sub_ok && b30) ? SUB : ADD};
         3'b100:  return {1'b1, XOR};
         3'b110:  return {1'b1, OR};
         3'b111:  return {1'b1, AND};
         default: return 4'b0000;
      endcase
   endfunction

   // Scoreboard monitor: compare every presented cycle against the model.
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         out_t  e;
         string n;
         e = exp_q.pop_front();
         n = name_q.pop_front();
         check(n, {13'b0, act_out()}, {13'b0, e});
      end
   end

   // One DUT cycle: drive its inputs after the edge and queue its expectation.
   task automatic issue(string nm, out_t o, logic rdy, logic z, logic [31:0] ins);
      @(posedge clk);
      #1;
      mem_ready = rdy;
      zero      = z;
      instr     = ins;
      exp_q.push_back(o);
      name_q.push_back(nm);
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 8) begin
         @(negedge clk);
         #1;
         k++;
      end
      check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
   endtask

   // Assert reset mid-cycle; outputs must drop at once.
   task automatic do_reset(string label);
      rst_n     = 1'b0;
      mem_ready = 1'b1;
      #1;
      check({label, "_outs_zero"}, {13'b0, act_out()}, 32'd0);
      check({label, "_state_zero"}, {28'b0, state}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic do_trap();
      out_t o;
      o = '0;
      o.illegal = 1'b1;
      for (int i = 0; i < 10; i++) issue("trap", o, rbit(), rbit(), $urandom);
      drain();
      do_reset("trap_reset");
   endtask

   task automatic aluwb();
      out_t o;
      o = '0;
      o.reg_write = 1'b1;
      issue("aluwb", o, rbit(), rbit(), instr);
   endtask

   // Reference model: emit the expected cycle sequence of one instruction.
   // fd/md = wait cycles before mem_ready in fetch/data access; zb = zero flag
   // during a branch; abort >= 0 resets the DUT after that many data waits.
   task automatic run_instr(logic [31:0] ins, int fd, int md, logic zb, int abort);
      out_t       o;
      logic [6:0] op;
      logic [2:0] f3;
      logic [3:0] ar;
      op = ins[6:0];
      f3 = ins[14:12];

      o = alu(2'b00, 2'b10, ADD, 3'b000, 2'b10);
      o.mem_req = 1'b1;
      for (int i = 0; i < fd; i++) issue("fetch_wait", o, 1'b0, rbit(), $urandom);
      o.ir_write = 1'b1;
      o.pc_write = 1'b1;
      issue("fetch", o, 1'b1, rbit(), ins);

      issue("decode", alu(2'b01, 2'b01, ADD, (op == OP_JAL) ? 3'b011 : 3'b010, 2'b00),
            rbit(), rbit(), ins);

      case (op)
         OP_LOAD, OP_STORE: begin
            issue("memadr", alu(2'b10, 2'b01, ADD, (op == OP_STORE) ? 3'b001 : 3'b000, 2'b00),
                  rbit(), rbit(), ins);
            o = '0;
            o.mem_req  = 1'b1;
            o.addr_src = 1'b1;
            o.mem_we   = (op == OP_STORE);
            for (int i = 0; i < md; i++) begin
               if (i == abort) begin
                  drain();
                  do_reset("memwr_abort");
                  return;
               end
               issue((op == OP_STORE) ? "memwr_wait" : "memrd_wait", o, 1'b0, rbit(), ins);
            end
            issue((op == OP_STORE) ? "memwr" : "memrd", o, 1'b1, rbit(), ins);
            if (op == OP_LOAD) begin
               o = '0;
               o.reg_write  = 1'b1;
               o.result_src = 2'b01;
               issue("memwb", o, rbit(), rbit(), ins);
            end
         end
         OP_RTYPE, OP_ITYPE: begin
            ar = arith_op(f3, op == OP_RTYPE, ins[30]);
            issue((op == OP_RTYPE) ? "execr" : "execi",
                  alu(2'b10, (op == OP_RTYPE) ? 2'b00 : 2'b01, ar[2:0], 3'b000, 2'b00),
                  rbit(), rbit(), ins);
            if (ar[3]) aluwb();
            else       do_trap();
         end
         OP_BRANCH: begin
            o = alu(2'b10, 2'b00, SUB, 3'b000, 2'b00);
            if (f3 == 3'b000)      o.pc_write = zb;
            else if (f3 == 3'b001) o.pc_write = ~zb;
            issue("branch", o, rbit(), zb, ins);
            if (f3 > 3'b001) do_trap();
         end
         OP_JAL: begin
            o = alu(2'b01, 2'b10, ADD, 3'b000, 2'b00);
            o.pc_write = 1'b1;
            issue("jal", o, rbit(), rbit(), ins);
            aluwb();
         end
         OP_JALR: begin
            issue("jalr", alu(2'b10, 2'b01, ADD, 3'b000, 2'b00), rbit(), rbit(), ins);
            o = alu(2'b01, 2'b10, ADD, 3'b000, 2'b00);
            o.pc_write = 1'b1;
            issue("jalr2", o, rbit(), rbit(), ins);
            aluwb();
         end
         OP_LUI: begin
            issue("lui", alu(2'b11, 2'b01, ADD, 3'b100, 2'b00), rbit(), rbit(), ins);
            aluwb();
         end
         default: do_trap();
      endcase
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: run did not complete, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] ins;
      int          kind;
      rst_n     = 1'b0;
      instr     = 32'h0;
      zero      = 1'b0;
      mem_ready = 1'b1;
      #3;
      check("reset_outs_zero", {13'b0, act_out()}, 32'd0);
      check("reset_state_zero", {28'b0, state}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      check("reset_held_outs_zero", {13'b0, act_out()}, 32'd0);
      rst_n = 1'b1;

      run_instr(32'h002081B3, 0, 0, 1'b0, -1);   // add x3,x1,x2
      run_instr(32'h0000A183, 1, 3, 1'b0, -1);   // lw, data ready after 3 waits
      run_instr(32'h00209463, 0, 0, 1'b0, -1);   // bne, taken
      run_instr(32'h00209463, 2, 0, 1'b1, -1);   // bne, not taken
      run_instr(32'h000080E7, 0, 0, 1'b0, -1);   // jalr
      run_instr(32'h0020A223, 0, 5, 1'b0,  2);   // sw, reset during the wait
      run_instr(32'h002081B3, 0, 0, 1'b0, -1);   // restart from FETCH
      run_instr(32'hFFFFFFFF, 0, 0, 1'b0, -1);   // illegal -> TRAP

      for (int n = 0; n < 150; n++) begin
         ins  = $urandom;
         kind = $urandom_range(0, 8);
         case (kind)
            0: ins[6:0] = OP_LOAD;
            1: ins[6:0] = OP_STORE;
            2: ins[6:0] = OP_RTYPE;
            3: ins[6:0] = OP_ITYPE;
            4: ins[6:0] = OP_BRANCH;
            5: ins[6:0] = OP_JAL;
            6: ins[6:0] = OP_JALR;
            7: ins[6:0] = OP_LUI;
            default: ins[6:0] = 7'($urandom);
         endcase
         // Keep most arithmetic/branch funct3 legal so traps stay occasional.
         if ((kind == 2 || kind == 3) && $urandom_range(0, 7) != 0) begin
            case ($urandom_range(0, 3))
               0:       ins[14:12] = 3'b000;
               1:       ins[14:12] = 3'b100;
               2:       ins[14:12] = 3'b110;
               default: ins[14:12] = 3'b111;
            endcase
         end
         if (kind == 4 && $urandom_range(0, 7) != 0) ins[14:12] = {2'b00, rbit()};
         run_instr(ins, $urandom_range(0, 2), $urandom_range(0, 3), rbit(), -1);
      end

      drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  clock (rising edge); reset is asynchronous and active-low.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: instr  in  32  instruction register contents; zero  in  1  ALU equal flag (rs1==rs2).
REQ-004 SHALL have ports: mem_ready  in  1  unified memory done; mem_req  out  1  memory request; mem_we  out  1  write enable.
REQ-005 SHALL have ports: addr_src  out  1  memory address select (0 PC, 1 ALUOut); ir_write, pc_write, reg_write  out  1 each.
REQ-006 SHALL have ports: alu_src_a  out  2  (00 PC, 01 oldPC, 10 rs1, 11 zero); alu_src_b  out  2  (00 rs2, 01 imm, 10 const 4).
REQ-007 SHALL have ports: alu_ctrl  out  3  (000 add, 001 sub, 010 and, 011 or, 100 xor); imm_src  out  3  (000 I, 001 S, 010 B, 011 J, 100 U).
REQ-008 SHALL have ports: result_src  out  2  (00 ALUOut, 01 mem data, 10 ALU result); illegal  out  1  sticky trap flag; state  out  4  debug.

Function
REQ-009 SHALL implement a Moore FSM, one state per cycle except memory states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, JALR2, LUI, TRAP.
REQ-010 SHALL, in FETCH, drive mem_req=1, addr_src=0, alu_src_a=00, alu_src_b=10, alu_ctrl=000, result_src=10; hold until mem_ready=1, then pulse ir_write=1 and pc_write=1 that cycle and go to DECODE.
REQ-011 SHALL, in DECODE, drive alu_src_a=01, alu_src_b=01, add, imm_src=011 if opcode 1101111 else 010; next state by opcode: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BRANCH, 1101111->JAL, 1100111->JALR, 0110111->LUI, other->TRAP.
REQ-012 SHALL, in MEMADR, drive alu_src_a=10, alu_src_b=01, add, imm_src=000 (lw) or 001 (sw); next MEMRD for lw, MEMWR for sw.
REQ-013 SHALL, in MEMRD, drive mem_req=1, addr_src=1, hold until mem_ready, then MEMWB; MEMWB drives reg_write=1, result_src=01, then FETCH.
REQ-014 SHALL, in MEMWR, drive mem_req=1, mem_we=1, addr_src=1, hold until mem_ready, then FETCH.
REQ-015 SHALL, in EXECR, drive alu_src_a=10, alu_src_b=00; funct3 000 with instr[30]=1 -> sub, else add; 100 xor; 110 or; 111 and; any other funct3 -> TRAP; valid -> ALUWB.
REQ-016 SHALL, in EXECI, drive alu_src_a=10, alu_src_b=01, imm_src=000, funct3 decoded as REQ-015 without sub; ALUWB drives reg_write=1, result_src=00, then FETCH.
REQ-017 SHALL, in BRANCH, drive alu_src_a=10, alu_src_b=00, sub, result_src=00; pc_write=zero for funct3 000 (beq), ~zero for 001 (bne), other funct3 -> TRAP; then FETCH.
REQ-018 SHALL, in JAL and JALR2, drive alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1, then ALUWB (link = oldPC+4).
REQ-019 SHALL, in JALR, drive alu_src_a=10, alu_src_b=01, imm_src=000, add, then JALR2.
REQ-020 SHALL, in LUI, drive alu_src_a=11, alu_src_b=01, imm_src=100, add, then ALUWB.
REQ-021 SHALL, in TRAP, set illegal=1, hold all write/request strobes at 0, and remain in TRAP until reset.
REQ-022 SHALL drive every output not listed for a state to 0.
REQ-023 SHALL keep mem_req, mem_we, addr_src stable while waiting on mem_ready; mem_ready outside memory states SHALL be ignored.
REQ-024 SHALL sample instr only in DECODE and later states (IR stable after FETCH).

Reset
REQ-025 SHALL, on rst_n=0, asynchronously enter FETCH and force all outputs to 0 and illegal=0, including mid-transaction (mem_req drops immediately).
REQ-026 SHALL begin FETCH with mem_req=1 on the first clock edge after rst_n rises.

Verification
REQ-027 add x3,x1,x2 (0x002081B3), mem_ready=1 in FETCH -> FETCH, DECODE, EXECR, ALUWB; reg_write=1 only in ALUWB; 4 cycles.
REQ-028 lw (0x0000A183), mem_ready delayed 3 cycles in MEMRD -> mem_req/addr_src=1 held 4 cycles; MEMWB result_src=01, reg_write=1.
REQ-029 bne (0x00209463), zero=0 -> pc_write=1 in BRANCH; zero=1 -> pc_write=0.
REQ-030 jalr (0x000080E7) -> DECODE, JALR, JALR2 (pc_write=1), ALUWB (reg_write=1).
REQ-031 instr 0xFFFFFFFF -> TRAP after DECODE, illegal=1 sticky, no strobes for 10 cycles; rst_n=0 clears.
REQ-032 rst_n pulsed low during MEMWR wait -> mem_req, mem_we 0 same cycle; restart in FETCH.
